// File: rtl/snn_pkg.sv
// Shared definitions for the approximate SNN datapath.
//  - state_t           : membrane stage FSM states
//  - VMEM_W            : membrane potential width
//  - *_DEF             : default neuron constants
//  - sat_select()      : saturating select for the approximate integrator
package snn_pkg;

  localparam int VMEM_W = 16;

  localparam logic [VMEM_W-1:0] THRESH_DEF     = 16'h0400;
  localparam int unsigned       LEAK_SHIFT_DEF = 32'd4;
  localparam logic [VMEM_W-1:0] RESET_VAL_DEF  = 16'h0000;

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_LEAK = 2'd1,
    S_FIRE = 2'd2
  } state_t;

  // Clamp to all-ones when the (wrapped) approximate sum lost its MSB:
  // both operands large, or one large operand and a result that fell below 2^15.
  function automatic logic [VMEM_W-1:0] sat_select(
    input logic [VMEM_W-1:0] a,
    input logic [VMEM_W-1:0] b,
    input logic [VMEM_W-1:0] sum
  );
    logic sat;
    sat = (a[VMEM_W-1] & b[VMEM_W-1]) |
          ((a[VMEM_W-1] | b[VMEM_W-1]) & ~sum[VMEM_W-1]);
    return sat ? {VMEM_W{1'b1}} : sum;
  endfunction

endpackage

// File: rtl/add2x16_approx.sv
// Approximate 16-bit adder, purely combinational.
//  a  in 16  first operand (membrane potential)
//  b  in 16  second operand (synaptic weight)
//  o  out 16 approximate sum, carry-out discarded
// The low three result bits pass b through unchanged; the carry into bit 3
// is predicted from a[2] alone, and bits [15:3] are an exact add.
module add2x16_approx (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] o
);

  logic [12:0] hi_s;

  assign hi_s = a[15:3] + b[15:3] + {12'd0, a[2]};
  assign o    = {hi_s, b[2:0]};

endmodule

// File: rtl/lif_membrane_accum.sv
// Leaky integrate-and-fire membrane stage.
//  clk, rst_n               clock, asynchronous active-low reset
//  in_valid/in_ready/in_weight      weight stream (one weight per cycle)
//  step_valid/step_ready            end-of-timestep request
//  spike_valid/spike_ready/spike_fired  spike token, held until accepted
//  vmem                     registered membrane potential
//  fire_cnt                 fired-spike counter, wraps
// A weight offered together with a step is always taken first.
module lif_membrane_accum
  import snn_pkg::*;
#(
  parameter logic [VMEM_W-1:0] THRESH     = THRESH_DEF,
  parameter int unsigned       LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter logic [VMEM_W-1:0] RESET_VAL  = RESET_VAL_DEF,
  parameter int unsigned       CNT_W      = 32'd8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VMEM_W-1:0] in_weight,
  input  logic              step_valid,
  output logic              step_ready,
  output logic              spike_valid,
  input  logic              spike_ready,
  output logic              spike_fired,
  output logic [VMEM_W-1:0] vmem,
  output logic [CNT_W-1:0]  fire_cnt
);

  state_t            state_q, state_d;
  logic [VMEM_W-1:0] vmem_q, vmem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              spike_valid_q, spike_valid_d;
  logic              spike_fired_q, spike_fired_d;

  logic [VMEM_W-1:0] sum_s;
  logic [VMEM_W-1:0] integ_s;
  logic [VMEM_W-1:0] leak_amt_s;
  logic [VMEM_W-1:0] leaked_s;

  add2x16_approx u_add (
    .a (vmem_q),
    .b (in_weight),
    .o (sum_s)
  );

  // Integration result and leak arithmetic (leak subtract never underflows).
  always_comb begin
    integ_s    = sat_select(vmem_q, in_weight, sum_s);
    leak_amt_s = (LEAK_SHIFT == 32'd0) ? {VMEM_W{1'b0}} : (vmem_q >> LEAK_SHIFT);
    leaked_s   = vmem_q - leak_amt_s;
  end

  // Handshake readies are decoded straight from the state.
  always_comb begin
    in_ready   = (state_q == S_ACC);
    step_ready = (state_q == S_ACC) & ~in_valid;
  end

  // Next-state, membrane, token and counter logic.
  always_comb begin
    state_d       = state_q;
    vmem_d        = vmem_q;
    cnt_d         = cnt_q;
    spike_valid_d = spike_valid_q;
    spike_fired_d = spike_fired_q;
    case (state_q)
      S_ACC: begin
        if (in_valid) begin
          vmem_d = integ_s;
        end else if (step_valid) begin
          state_d = S_LEAK;
        end else begin
          state_d = S_ACC;
        end
      end
      S_LEAK: begin
        vmem_d        = leaked_s;
        state_d       = S_FIRE;
        spike_valid_d = 1'b1;
        // A saturated potential fires regardless of how far leak pulls it down.
        spike_fired_d = (leaked_s >= THRESH) | (vmem_q == {VMEM_W{1'b1}});
      end
      S_FIRE: begin
        if (spike_ready) begin
          spike_valid_d = 1'b0;
          spike_fired_d = 1'b0;
          state_d       = S_ACC;
          if (spike_fired_q) begin
            vmem_d = RESET_VAL;
            cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            vmem_d = vmem_q;
          end
        end else begin
          state_d = S_FIRE;
        end
      end
      default: begin
        state_d       = S_ACC;
        spike_valid_d = 1'b0;
        spike_fired_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_ACC;
      vmem_q        <= {VMEM_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      spike_valid_q <= 1'b0;
      spike_fired_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      vmem_q        <= vmem_d;
      cnt_q         <= cnt_d;
      spike_valid_q <= spike_valid_d;
      spike_fired_q <= spike_fired_d;
    end
  end

  assign vmem        = vmem_q;
  assign fire_cnt    = cnt_q;
  assign spike_valid = spike_valid_q;
  assign spike_fired = spike_fired_q;

endmodule

// File: tb/tb_lif_membrane_accum.sv
// Directed bench for lif_membrane_accum with an expected-value scoreboard:
// expected membrane values and spike tokens are queued when stimulus is
// driven and popped when the DUT presents the corresponding result.
module tb_lif_membrane_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_weight;
  logic        step_valid;
  logic        step_ready;
  logic        spike_valid;
  logic        spike_ready;
  logic        spike_fired;
  logic [15:0] vmem;
  logic [7:0]  fire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] vq[$];
  logic        sq[$];

  lif_membrane_accum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_weight   (in_weight),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_fired (spike_fired),
    .vmem        (vmem),
    .fire_cnt    (fire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one weight; expected vmem is queued and compared after the edge.
  task automatic send_weight(input logic [15:0] w, input logic [15:0] exp_v);
    logic [15:0] e;
    in_valid  = 1'b1;
    in_weight = w;
    #1;
    check("in_ready_acc", in_ready, 1);
    vq.push_back(exp_v);
    tick();
    in_valid = 1'b0;
    e = vq.pop_front();
    check("vmem_integ", vmem, e);
  endtask

  // End a timestep; optionally hold the token for `hold` cycles and ack it.
  task automatic do_step(input logic exp_fired, input logic [15:0] exp_leak,
                         input int hold, input logic ack,
                         input logic [15:0] exp_after, input logic [7:0] exp_cnt);
    logic [15:0] ev;
    logic        ef;
    step_valid = 1'b1;
    #1;
    check("step_ready_acc", step_ready, 1);
    sq.push_back(exp_fired);
    vq.push_back(exp_leak);
    tick();
    step_valid = 1'b0;
    check("leak_no_token", spike_valid, 0);
    check("leak_in_ready", in_ready, 0);
    tick();
    ev = vq.pop_front();
    ef = sq.pop_front();
    check("token_valid_2cyc", spike_valid, 1);
    check("token_fired", spike_fired, ef);
    check("vmem_leaked", vmem, ev);
    for (int i = 0; i < hold; i++) begin
      in_valid    = 1'b1;
      in_weight   = 16'h1234;
      spike_ready = 1'b0;
      tick();
      check("bp_valid", spike_valid, 1);
      check("bp_fired", spike_fired, ef);
      check("bp_vmem", vmem, ev);
      check("bp_in_ready", in_ready, 0);
      check("bp_step_ready", step_ready, 0);
    end
    in_valid = 1'b0;
    if (ack) begin
      spike_ready = 1'b1;
      tick();
      spike_ready = 1'b0;
      check("ack_valid", spike_valid, 0);
      check("ack_vmem", vmem, exp_after);
      check("ack_cnt", fire_cnt, exp_cnt);
      check("ack_in_ready", in_ready, 1);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_vmem", vmem, 0);
    check("rst_valid", spike_valid, 0);
    check("rst_fired", spike_fired, 0);
    check("rst_cnt", fire_cnt, 0);
    vq.delete();
    sq.delete();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_weight   = 16'h0000;
    step_valid  = 1'b0;
    spike_ready = 1'b0;
    tick();
    tick();
    check("reset_vmem", vmem, 0);
    check("reset_cnt", fire_cnt, 0);
    check("reset_valid", spike_valid, 0);
    check("reset_fired", spike_fired, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_step_ready", step_ready, 1);
    rst_n = 1'b1;
    tick();

    // Exact path.
    send_weight(16'h0100, 16'h0100);
    send_weight(16'h0200, 16'h0300);

    // Approximate path: carry into bit 3 predicted from a[2].
    pulse_reset();
    send_weight(16'h0005, 16'h0005);
    send_weight(16'h0003, 16'h000B);

    // Saturation, then a fired step with immediate ack.
    pulse_reset();
    send_weight(16'hF000, 16'hF000);
    send_weight(16'h2000, 16'hFFFF);
    do_step(1'b1, 16'hF000, 0, 1'b1, 16'h0000, 8'd1);

    // Leak without fire, with 5 cycles of backpressure.
    send_weight(16'h0100, 16'h0100);
    do_step(1'b0, 16'h00F0, 5, 1'b1, 16'h00F0, 8'd1);

    // Weight beats a simultaneous step; the step is taken next cycle.
    in_valid   = 1'b1;
    in_weight  = 16'h0010;
    step_valid = 1'b1;
    #1;
    check("prio_step_ready", step_ready, 0);
    check("prio_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("prio_vmem", vmem, 16'h0100);
    do_step(1'b0, 16'h00F0, 0, 1'b1, 16'h00F0, 8'd1);

    // Threshold boundary: 0x444 leaks to exactly 0x400 and fires.
    pulse_reset();
    send_weight(16'h0444, 16'h0444);
    do_step(1'b1, 16'h0400, 1, 1'b1, 16'h0000, 8'd1);
    // 0x443 leaks to 0x3FF and does not fire.
    send_weight(16'h0443, 16'h0443);
    do_step(1'b0, 16'h03FF, 0, 1'b1, 16'h03FF, 8'd1);

    // Reset while a fired token is pending.
    pulse_reset();
    send_weight(16'h0500, 16'h0500);
    do_step(1'b1, 16'h04B0, 2, 1'b0, 16'h0000, 8'd0);
    pulse_reset();
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_valid", spike_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
